memory_store_rmw: RTL and testbench

//  Store-side counterpart of the data-memory load formatter: accepts SW/SB requests from the

---
 rtl/memory_store_rmw.sv | 161 ++++++++++++++++
 tb/tb_memory_store_rmw.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_store_rmw.sv
// Store formatter for a word-wide synchronous data memory: SW writes directly, SB does read-merge-write.
// Optional build macro MISALIGN_TRAP_EN rejects misaligned SW requests with a misalign pulse.
module memory_store_rmw #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic                  StSrc,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] WD,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rd,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic                  st_done,
    output logic                  misalign
);

    localparam int LANES     = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(LANES);
    localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        MERGE,
        WRITE
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic                    accept;
    logic [LANE_BITS-1:0]    req_lane;
    logic [7:0]              req_byte;
    logic [DATA_WIDTH-1:0]   merged;

    logic [ADDR_WIDTH-1:0]   addr_nx;
    logic                    re_nx;
    logic                    we_nx;
    logic [DATA_WIDTH-1:0]   wd_nx;
    logic                    done_nx;

`ifdef MISALIGN_TRAP_EN
    logic                    misalign_nx;
    logic                    sw_misaligned;
    logic                    misalign_q;

    assign sw_misaligned = (A & LANE_MASK) != '0;
    assign misalign      = misalign_q;
`else
    assign misalign      = 1'b0;
`endif

    assign st_ready = (state == IDLE);
    assign accept   = st_valid && st_ready;

    // Only the addressed byte lane of the freshly read word is replaced.
    always_comb begin
        merged = mem_rd;
        for (int k = 0; k < LANES; k++) begin
            if (req_lane == LANE_BITS'(k)) begin
                merged[8*k +: 8] = req_byte;
            end
        end
    end

    always_comb begin
        state_nx = state;
        addr_nx  = mem_addr;
        re_nx    = 1'b0;
        we_nx    = 1'b0;
        wd_nx    = mem_wd;
        done_nx  = 1'b0;
`ifdef MISALIGN_TRAP_EN
        misalign_nx = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    if (StSrc) begin
                        state_nx = READ;
                        re_nx    = 1'b1;
                        addr_nx  = A & ~LANE_MASK;
                    end else begin
`ifdef MISALIGN_TRAP_EN
                        if (sw_misaligned) begin
                            misalign_nx = 1'b1;
                        end else begin
                            state_nx = WRITE;
                            we_nx    = 1'b1;
                            done_nx  = 1'b1;
                            addr_nx  = A & ~LANE_MASK;
                            wd_nx    = WD;
                        end
`else
                        state_nx = WRITE;
                        we_nx    = 1'b1;
                        done_nx  = 1'b1;
                        addr_nx  = A & ~LANE_MASK;
                        wd_nx    = WD;
`endif
                    end
                end
            end
            READ: begin
                state_nx = MERGE;
            end
            MERGE: begin
                // mem_addr still holds the aligned word address from the read.
                state_nx = WRITE;
                we_nx    = 1'b1;
                done_nx  = 1'b1;
                wd_nx    = merged;
            end
            WRITE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            mem_addr <= '0;
            mem_re   <= 1'b0;
            mem_we   <= 1'b0;
            mem_wd   <= '0;
            st_done  <= 1'b0;
            req_lane <= '0;
            req_byte <= '0;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state    <= state_nx;
            mem_addr <= addr_nx;
            mem_re   <= re_nx;
            mem_we   <= we_nx;
            mem_wd   <= wd_nx;
            st_done  <= done_nx;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= misalign_nx;
`endif
            if (accept) begin
                req_lane <= A[LANE_BITS-1:0];
                req_byte <= WD[7:0];
            end
        end
    end

    // Single-port memory: a read and a write can never share a cycle.
    assert property (@(posedge clk) !(mem_re && mem_we));

endmodule

// File: tb/tb_memory_store_rmw.sv
// Directed bench for memory_store_rmw with a small synchronous memory model and hand-computed expectations.
// Build with MISALIGN_TRAP_EN defined to exercise the misaligned-SW trap path.
module tb_memory_store_rmw;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic        StSrc;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic [31:0] mem_rd;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic        st_done;
    logic        misalign;

    int vectors;
    int miscompares;
    int we_count;
    int we_before;

    logic [31:0] mem [0:63];
    logic        preload_en;
    logic [5:0]  preload_idx;
    logic [31:0] preload_data;

    memory_store_rmw #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
        .StSrc(StSrc), .A(A), .WD(WD), .mem_addr(mem_addr), .mem_re(mem_re),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_wd(mem_wd), .st_done(st_done),
        .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: read data appears the cycle after mem_re.
    always @(posedge clk) begin
        if (preload_en) mem[preload_idx] <= preload_data;
        else if (mem_we) mem[mem_addr[7:2]] <= mem_wd;
        if (mem_re) mem_rd <= mem[mem_addr[7:2]];
        if (mem_we) we_count <= we_count + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        preload_en   = 1'b1;
        preload_idx  = idx;
        preload_data = data;
        step();
        preload_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_we got %b exp 0", mem_we); end
        vectors++; if (mem_re !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_re got %b exp 0", mem_re); end
        vectors++; if (st_done !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_done got %b exp 0", st_done); end
        vectors++; if (misalign !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_misalign got %b exp 0", misalign); end
        vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_addr got %h exp 0", mem_addr); end
        vectors++; if (mem_wd !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_wd got %h exp 0", mem_wd); end
        rst_n = 1'b1;
        step();
        vectors++; if (st_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_ready got %b exp 1", st_ready); end
    endtask

    task automatic test_sw();
        st_valid = 1'b1; StSrc = 1'b0; A = 32'h10; WD = 32'hDEADBEEF;
        step();
        st_valid = 1'b0;
        vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("[TB] FAIL sw_we got %b exp 1", mem_we); end
        vectors++; if (mem_re !== 1'b0) begin miscompares++; $display("[TB] FAIL sw_re got %b exp 0", mem_re); end
        vectors++; if (mem_addr !== 32'h10) begin miscompares++; $display("[TB] FAIL sw_addr got %h exp 00000010", mem_addr); end
        vectors++; if (mem_wd !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL sw_wd got %h exp deadbeef", mem_wd); end
        vectors++; if (st_done !== 1'b1) begin miscompares++; $display("[TB] FAIL sw_done got %b exp 1", st_done); end
        vectors++; if (st_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL sw_busy got %b exp 0", st_ready); end
        step();
        vectors++; if (st_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL sw_ready_n2 got %b exp 1", st_ready); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL sw_we_drop got %b exp 0", mem_we); end
        vectors++; if (st_done !== 1'b0) begin miscompares++; $display("[TB] FAIL sw_done_drop got %b exp 0", st_done); end
    endtask

    task automatic test_sb();
        preload(6'd8, 32'h11223344);
        st_valid = 1'b1; StSrc = 1'b1; A = 32'h22; WD = 32'h000000AB;
        step();
        st_valid = 1'b0;
        vectors++; if (mem_re !== 1'b1) begin miscompares++; $display("[TB] FAIL sb_re got %b exp 1", mem_re); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL sb_we_n1 got %b exp 0", mem_we); end
        vectors++; if (mem_addr !== 32'h20) begin miscompares++; $display("[TB] FAIL sb_raddr got %h exp 00000020", mem_addr); end
        step();
        vectors++; if (mem_re !== 1'b0 || mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL sb_merge_idle got re=%b we=%b exp 0 0", mem_re, mem_we); end
        vectors++; if (st_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL sb_busy_n2 got %b exp 0", st_ready); end
        step();
        vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("[TB] FAIL sb_we got %b exp 1", mem_we); end
        vectors++; if (mem_wd !== 32'h11AB3344) begin miscompares++; $display("[TB] FAIL sb_wd got %h exp 11ab3344", mem_wd); end
        vectors++; if (mem_addr !== 32'h20) begin miscompares++; $display("[TB] FAIL sb_waddr got %h exp 00000020", mem_addr); end
        vectors++; if (st_done !== 1'b1) begin miscompares++; $display("[TB] FAIL sb_done got %b exp 1", st_done); end
        step();
        vectors++; if (st_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL sb_ready_n4 got %b exp 1", st_ready); end
    endtask

    task automatic test_lanes();
        preload(6'd12, 32'hFFFFFFFF);
        preload(6'd13, 32'hFFFFFFFF);
        st_valid = 1'b1; StSrc = 1'b1; A = 32'h30; WD = 32'h00000000;
        step();
        st_valid = 1'b0;
        step();
        step();
        vectors++; if (mem_wd !== 32'hFFFFFF00) begin miscompares++; $display("[TB] FAIL lane0_wd got %h exp ffffff00", mem_wd); end
        vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("[TB] FAIL lane0_we got %b exp 1", mem_we); end
        step();
        st_valid = 1'b1; StSrc = 1'b1; A = 32'h37; WD = 32'h12345600;
        step();
        st_valid = 1'b0;
        vectors++; if (mem_addr !== 32'h34) begin miscompares++; $display("[TB] FAIL lane3_raddr got %h exp 00000034", mem_addr); end
        step();
        step();
        vectors++; if (mem_wd !== 32'h00FFFFFF) begin miscompares++; $display("[TB] FAIL lane3_wd got %h exp 00ffffff", mem_wd); end
        vectors++; if (mem_addr !== 32'h34) begin miscompares++; $display("[TB] FAIL lane3_waddr got %h exp 00000034", mem_addr); end
        step();
    endtask

    task automatic test_back_to_back();
        preload(6'd16, 32'h55667788);
        st_valid = 1'b1; StSrc = 1'b1; A = 32'h40; WD = 32'h000000CC;
        step();
        StSrc = 1'b0; A = 32'h44; WD = 32'h12345678;
        vectors++; if (st_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_busy_n1 got %b exp 0", st_ready); end
        step();
        vectors++; if (st_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_busy_n2 got %b exp 0", st_ready); end
        step();
        vectors++; if (st_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_busy_n3 got %b exp 0", st_ready); end
        vectors++; if (mem_wd !== 32'h556677CC) begin miscompares++; $display("[TB] FAIL b2b_sb_wd got %h exp 556677cc", mem_wd); end
        step();
        vectors++; if (st_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_ready_n4 got %b exp 1", st_ready); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_we_n4 got %b exp 0", mem_we); end
        step();
        st_valid = 1'b0;
        vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_sw_we got %b exp 1", mem_we); end
        vectors++; if (mem_addr !== 32'h44) begin miscompares++; $display("[TB] FAIL b2b_sw_addr got %h exp 00000044", mem_addr); end
        vectors++; if (mem_wd !== 32'h12345678) begin miscompares++; $display("[TB] FAIL b2b_sw_wd got %h exp 12345678", mem_wd); end
        step();
    endtask

    task automatic test_reset_abort();
        preload(6'd20, 32'hAAAAAAAA);
        we_before = we_count;
        st_valid = 1'b1; StSrc = 1'b1; A = 32'h51; WD = 32'h00000055;
        step();
        st_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_we got %b exp 0", mem_we); end
        vectors++; if (mem_re !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_re got %b exp 0", mem_re); end
        vectors++; if (st_done !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_done got %b exp 0", st_done); end
        vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL abort_addr got %h exp 0", mem_addr); end
        vectors++; if (mem_wd !== 32'h0) begin miscompares++; $display("[TB] FAIL abort_wd got %h exp 0", mem_wd); end
        vectors++; if (st_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_ready got %b exp 1", st_ready); end
        rst_n = 1'b1;
        step();
        step();
        step();
        vectors++; if (we_count !== we_before) begin miscompares++; $display("[TB] FAIL abort_writes got %0d exp %0d", we_count, we_before); end
    endtask

    task automatic test_misalign();
        we_before = we_count;
        st_valid = 1'b1; StSrc = 1'b0; A = 32'h13; WD = 32'hA5A5A5A5;
        step();
        st_valid = 1'b0;
`ifdef MISALIGN_TRAP_EN
        vectors++; if (misalign !== 1'b1) begin miscompares++; $display("[TB] FAIL mis_pulse got %b exp 1", misalign); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL mis_we got %b exp 0", mem_we); end
        vectors++; if (st_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL mis_ready got %b exp 1", st_ready); end
        step();
        vectors++; if (misalign !== 1'b0) begin miscompares++; $display("[TB] FAIL mis_drop got %b exp 0", misalign); end
        vectors++; if (we_count !== we_before) begin miscompares++; $display("[TB] FAIL mis_writes got %0d exp %0d", we_count, we_before); end
`else
        vectors++; if (misalign !== 1'b0) begin miscompares++; $display("[TB] FAIL mis_tied got %b exp 0", misalign); end
        vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("[TB] FAIL mis_we got %b exp 1", mem_we); end
        vectors++; if (mem_addr !== 32'h10) begin miscompares++; $display("[TB] FAIL mis_addr got %h exp 00000010", mem_addr); end
        vectors++; if (mem_wd !== 32'hA5A5A5A5) begin miscompares++; $display("[TB] FAIL mis_wd got %h exp a5a5a5a5", mem_wd); end
        step();
`endif
        step();
        // SB to an odd address is never trapped.
        st_valid = 1'b1; StSrc = 1'b1; A = 32'h13; WD = 32'h0000005A;
        step();
        st_valid = 1'b0;
        vectors++; if (mem_re !== 1'b1 || misalign !== 1'b0) begin miscompares++; $display("[TB] FAIL mis_sb got re=%b misalign=%b exp 1 0", mem_re, misalign); end
        step();
        step();
        step();
    endtask

    initial begin
        vectors = 0; miscompares = 0; we_count = 0;
        rst_n = 1'b0; st_valid = 1'b0; StSrc = 1'b0; A = '0; WD = '0;
        mem_rd = '0; preload_en = 1'b0; preload_idx = '0; preload_data = '0;
        test_reset();
        test_sw();
        test_sb();
        test_lanes();
        test_back_to_back();
        test_reset_abort();
        test_misalign();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
